// File: rtl/mmi_arbiter_if.sv
// One memory-mapped valid/ready/wstrb bus port (a master or the register-bank port).
// The bank returns no error response, so err is only driven towards masters.
interface mmi_arbiter_if #(
    parameter int unsigned AW = 3
);
    logic          valid;
    logic [3:0]    wstrb;
    logic [31:0]   wdata;
    logic [AW-1:0] addr;
    logic          ready;
    logic [31:0]   rdata;
    logic          err;

    modport master (
        output valid, wstrb, wdata, addr,
        input  ready, rdata
    );

    modport slave (
        input  valid, wstrb, wdata, addr,
        output ready, rdata, err
    );
endinterface

// File: rtl/mmi_arbiter.sv
// Two-master round-robin arbiter in front of the register bank: latches the winning
// request, waits for the bank acknowledge or a timeout, then pulses the owner's ready.
module mmi_arbiter #(
    parameter int unsigned AW      = 3,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    mmi_arbiter_if.slave  m0,
    mmi_arbiter_if.slave  m1,
    mmi_arbiter_if.master s,
    output logic [1:0]  gnt
);
    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

    state_e             state_q, state_d;
    logic [1:0]         gnt_q, gnt_d;
    logic               last_q, last_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [1:0]         mask_q, mask_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [1:0]         ready_q, ready_d;
    logic [1:0]         err_q, err_d;
    logic [1:0][31:0]   rdata_q, rdata_d;
    logic [1:0]         req;
    logic               win;
    logic               owner;

    // The just-served master is ignored for one IDLE cycle to swallow a late valid drop.
    assign req   = {m1.valid, m0.valid} & ~mask_q;
    assign owner = gnt_q[1];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        mask_d  = 2'b00;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        ready_d = 2'b00;
        err_d   = err_q;
        rdata_d = rdata_q;
        win     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    // Master 1 wins when alone, or on contention when master 0 was served last.
                    win     = req[1] & (~req[0] | ~last_q);
                    gnt_d   = win ? 2'b10 : 2'b01;
                    last_d  = win;
                    cnt_d   = '0;
                    wstrb_d = win ? m1.wstrb : m0.wstrb;
                    wdata_d = win ? m1.wdata : m0.wdata;
                    addr_d  = win ? m1.addr  : m0.addr;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (s.ready) begin
                    rdata_d[owner] = s.rdata;
                    err_d[owner]   = 1'b0;
                    ready_d        = gnt_q;
                    state_d        = StDrain;
                end else if (cnt_q == CntLast) begin
                    rdata_d[owner] = '0;
                    err_d[owner]   = 1'b1;
                    ready_d        = gnt_q;
                    state_d        = StDrain;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDrain: begin
                mask_d  = gnt_q;
                gnt_d   = 2'b00;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            mask_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            ready_q <= '0;
            err_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign s.valid  = (state_q == StBusy);
    assign s.wstrb  = wstrb_q;
    assign s.wdata  = wdata_q;
    assign s.addr   = addr_q;
    assign gnt      = gnt_q;

    assign m0.ready = ready_q[0];
    assign m0.rdata = rdata_q[0];
    assign m0.err   = err_q[0];
    assign m1.ready = ready_q[1];
    assign m1.rdata = rdata_q[1];
    assign m1.err   = err_q[1];
endmodule

// File: tb/tb_mmi_arbiter.sv
// Scoreboard bench for mmi_arbiter: directed scenarios plus random two-master traffic
// against a table-driven register-bank model.
module tb_mmi_arbiter;
    localparam int unsigned AW      = 3;
    localparam int unsigned TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] gnt;

    mmi_arbiter_if #(.AW(AW)) m0_bus ();
    mmi_arbiter_if #(.AW(AW)) m1_bus ();
    mmi_arbiter_if #(.AW(AW)) s_bus ();

    mmi_arbiter #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .m0  (m0_bus),
        .m1  (m1_bus),
        .s   (s_bus),
        .gnt (gnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Bank model: acknowledges one cycle after each valid cycle, data from a fixed table.
    logic [31:0] rdtab [8];
    bit          bank_dead = 1'b0;
    assign s_bus.err = 1'b0;
    always @(posedge clk) begin
        s_bus.ready <= !bank_dead && s_bus.valid;
        s_bus.rdata <= s_bus.valid ? rdtab[s_bus.addr] : $urandom;
    end

    // Expected responses {err, rdata} per master, and the request each master is holding.
    logic [32:0]     exp_q0 [$];
    logic [32:0]     exp_q1 [$];
    logic [AW+35:0]  cur_req [2];
    bit              outstanding [2];
    int              grant_seq [$];
    bit              abort_mode = 1'b0;

    task automatic drive(input int m, input bit v, input logic [AW-1:0] addr,
                         input logic [3:0] wstrb, input logic [31:0] wdata);
        if (m == 0) begin
            m0_bus.valid = v; m0_bus.addr = addr; m0_bus.wstrb = wstrb; m0_bus.wdata = wdata;
        end else begin
            m1_bus.valid = v; m1_bus.addr = addr; m1_bus.wstrb = wstrb; m1_bus.wdata = wdata;
        end
    endtask

    task automatic post_req(input int m, input logic [AW-1:0] addr, input logic [3:0] wstrb,
                            input logic [31:0] wdata, input bit expect_resp);
        logic [32:0] e;
        e = bank_dead ? {1'b1, 32'h0} : {1'b0, rdtab[addr]};
        if (expect_resp) begin
            if (m == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
        end
        cur_req[m]     = {addr, wstrb, wdata};
        outstanding[m] = 1'b1;
        drive(m, 1'b1, addr, wstrb, wdata);
    endtask

    // Call at posedge+#1; returns ready latency in cycles from the first sampled cycle.
    task automatic do_txn(input int m, input logic [AW-1:0] addr, input logic [3:0] wstrb,
                          input logic [31:0] wdata, input bit late, output int lat);
        int start;
        bit seen;
        post_req(m, addr, wstrb, wdata, 1'b1);
        start = cyc;
        seen  = 1'b0;
        lat   = -1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if ((m == 0 && m0_bus.ready) || (m == 1 && m1_bus.ready)) begin
                seen = 1'b1;
                lat  = cyc - start;
            end
        end
        if (!seen) fail_now($sformatf("m%0d ready wait: no ready within 100 cycles", m));
        @(posedge clk); #1;
        if (late) begin
            @(posedge clk); #1;
        end
        drive(m, 1'b0, addr, wstrb, wdata);
    endtask

    // Bank-side monitor: one transaction per outstanding request, stable latched payload.
    bit sv_prev = 1'b0;
    int sv_len  = 0;
    int sv_owner = 0;
    always @(negedge clk) begin
        if (s_bus.valid) begin
            if (!sv_prev) begin
                sv_owner = gnt[1] ? 1 : 0;
                grant_seq.push_back(sv_owner);
                checks++;
                if (gnt != 2'b01 && gnt != 2'b10) begin
                    errors++;
                    $display("FAIL gnt one-hot at issue: got %b, required 01 or 10", gnt);
                end
                checks++;
                if (!outstanding[sv_owner]) begin
                    errors++;
                    $display("FAIL duplicate issue for m%0d: got a transaction, required none",
                             sv_owner);
                end
                outstanding[sv_owner] = 1'b0;
                sv_len = 0;
            end
            sv_len++;
            check("s_addr/s_wstrb/s_wdata", {s_bus.addr, s_bus.wstrb, s_bus.wdata},
                  cur_req[sv_owner]);
        end else if (sv_prev && !abort_mode) begin
            check("s_valid length", sv_len, bank_dead ? TIMEOUT : 2);
        end
        sv_prev = s_bus.valid;
    end

    // Master-side monitor: pops the scoreboard on every ready pulse.
    bit [1:0] rdy_prev = 2'b00;
    task automatic mon_ready(input int m, input logic [31:0] rdata, input logic err);
        logic [32:0] e;
        check($sformatf("m%0d_ready single pulse", m), rdy_prev[m], 1'b0);
        check($sformatf("m%0d gnt at ready", m), gnt, (m == 0) ? 2'b01 : 2'b10);
        if ((m == 0 && exp_q0.size() == 0) || (m == 1 && exp_q1.size() == 0)) begin
            fail_now($sformatf("m%0d unexpected ready: got ready, required none", m));
        end else begin
            e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("m%0d_rdata", m), rdata, e[31:0]);
            check($sformatf("m%0d_err", m), err, e[32]);
        end
    endtask

    always @(negedge clk) begin
        if (m0_bus.ready) mon_ready(0, m0_bus.rdata, m0_bus.err);
        if (m1_bus.ready) mon_ready(1, m1_bus.rdata, m1_bus.err);
        if (m0_bus.ready && m1_bus.ready) fail_now("both m_ready high together");
        rdy_prev = {m1_bus.ready, m0_bus.ready};
    end

    task automatic check_reset(input string tag);
        check({tag, " gnt"}, gnt, 2'b00);
        check({tag, " s_valid"}, s_bus.valid, 1'b0);
        check({tag, " s_addr"}, s_bus.addr, '0);
        check({tag, " s_wstrb"}, s_bus.wstrb, 4'h0);
        check({tag, " s_wdata"}, s_bus.wdata, 32'h0);
        check({tag, " m0_ready"}, m0_bus.ready, 1'b0);
        check({tag, " m1_ready"}, m1_bus.ready, 1'b0);
        check({tag, " m0_err"}, m0_bus.err, 1'b0);
        check({tag, " m1_err"}, m1_bus.err, 1'b0);
        check({tag, " m0_rdata"}, m0_bus.rdata, 32'h0);
        check({tag, " m1_rdata"}, m1_bus.rdata, 32'h0);
    endtask

    task automatic rand_master(input int m, input int n_txn);
        int  lat;
        int  idle;
        bit  late;
        for (int n = 0; n < n_txn; n++) begin
            idle = $urandom_range(0, 3);
            repeat (idle) begin
                @(posedge clk); #1;
            end
            late = ($urandom_range(0, 3) == 0);
            do_txn(m, AW'($urandom), 4'($urandom), $urandom, late, lat);
            if (late) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int l0;
        int l1;
        int n0;

        for (int i = 0; i < 8; i++) rdtab[i] = $urandom | 32'h1;
        rdtab[3] = 32'h1234_5678;
        drive(0, 1'b0, '0, 4'h0, 32'h0);
        drive(1, 1'b0, '0, 4'h0, 32'h0);
        outstanding[0] = 1'b0;
        outstanding[1] = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset("reset");

        // Single read from m0 with a cycle-by-cycle timeline.
        @(posedge clk); #1;
        fork
            do_txn(0, 3'd3, 4'h0, 32'h0, 1'b0, lat);
            begin
                @(negedge clk); check("read t s_valid", s_bus.valid, 1'b0);
                @(negedge clk); check("read t+1 s_valid", s_bus.valid, 1'b1);
                check("read t+1 gnt", gnt, 2'b01);
                @(negedge clk); check("read t+2 s_valid", s_bus.valid, 1'b1);
                check("read t+2 gnt", gnt, 2'b01);
                @(negedge clk); check("read t+3 s_valid", s_bus.valid, 1'b0);
                check("read t+3 gnt", gnt, 2'b01);
                @(negedge clk); check("read t+4 gnt", gnt, 2'b00);
            end
        join
        check("read latency", lat, 3);

        // Byte write from m1.
        do_txn(1, 3'd5, 4'b0100, 32'h00AB_0000, 1'b0, lat);
        check("write latency", lat, 3);

        // Late drop from m0 with m1 idle: exactly one transaction.
        @(posedge clk); #1;
        n0 = grant_seq.size();
        do_txn(0, 3'd2, 4'hF, $urandom, 1'b1, lat);
        check("late-drop latency", lat, 3);
        repeat (3) @(posedge clk);
        #1 check("late-drop issue count", grant_seq.size(), n0 + 1);

        // Contention with both masters requesting from reset.
        rst = 1'b1;
        grant_seq.delete();
        fork
            begin
                do_txn(0, 3'd1, 4'hF, $urandom, 1'b0, l0);
                do_txn(0, 3'd4, 4'h0, 32'h0, 1'b0, l0);
            end
            begin
                do_txn(1, 3'd7, 4'h3, $urandom, 1'b0, l1);
                do_txn(1, 3'd2, 4'h0, 32'h0, 1'b0, l1);
            end
            begin
                @(posedge clk); #1 rst = 1'b0;
            end
        join
        check("contention grant count", grant_seq.size(), 4);
        for (int i = 0; i < 4 && i < grant_seq.size(); i++)
            check($sformatf("contention grant %0d", i), grant_seq[i], i % 2);

        // Timeout on m1 with a silent bank.
        @(posedge clk); #1;
        bank_dead = 1'b1;
        do_txn(1, 3'd6, 4'h0, 32'h0, 1'b0, lat);
        check("timeout latency", lat, TIMEOUT + 1);
        @(negedge clk);
        check("timeout then idle gnt", gnt, 2'b00);
        check("timeout then idle s_valid", s_bus.valid, 1'b0);
        @(posedge clk); #1;
        bank_dead = 1'b0;

        // m0 served last, then reset during its BUSY: m0 must still win the next contention.
        do_txn(0, 3'd0, 4'h0, 32'h0, 1'b0, lat);
        @(posedge clk); #1;
        post_req(0, 3'd1, 4'hF, 32'hDEAD_BEEF, 1'b0);
        @(posedge clk); #1;
        abort_mode = 1'b1;
        rst = 1'b1;
        drive(0, 1'b0, 3'd1, 4'hF, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset("reset in busy");
        @(posedge clk); #1;
        abort_mode = 1'b0;
        grant_seq.delete();
        fork
            do_txn(0, 3'd4, 4'h0, 32'h0, 1'b0, l0);
            do_txn(1, 3'd5, 4'h0, 32'h0, 1'b0, l1);
        join
        check("post-reset first grant", (grant_seq.size() > 0) ? grant_seq[0] : -1, 0);

        // Random traffic from both masters.
        fork
            rand_master(0, 30);
            rand_master(1, 30);
        join
        repeat (4) @(posedge clk);
        #1;
        check("m0 scoreboard drained", exp_q0.size(), 0);
        check("m1 scoreboard drained", exp_q1.size(), 0);
        check("no pending issue", {outstanding[1], outstanding[0]}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mmi_arbiter.md
# mmi_arbiter

Two-master round-robin arbiter for the memory-mapped register-bank bus of the smartcard SoC. It lets the CPU (master 0) and a secondary bus master (master 1, the loader/debug port) share the single valid/ready/wstrb port of the CPU–coprocessor–communication register bank. Requests are latched at grant, and every transaction completes. A transaction the slave never acknowledges completes through a timeout with an error flag.

## Interface
Parameters:
- AW, 3: address width, matching the register-bank address port.
- TIMEOUT, 16: maximum BUSY cycles waiting for s_ready before a forced error completion. Legal range 2..255.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- m0_valid  in  1  master 0 request; held until m0_ready.
- m0_wstrb  in  4  master 0 byte write strobes; 0 means read.
- m0_wdata  in  32  master 0 write data.
- m0_addr  in  AW  master 0 word address.
- m0_ready  out  1  one-cycle completion pulse to master 0.
- m0_rdata  out  32  read data; valid while m0_ready=1.
- m0_err  out  1  timeout completion; valid while m0_ready=1.
- m1_valid, m1_wstrb, m1_wdata, m1_addr, m1_ready, m1_rdata, m1_err: same as the m0 ports, for master 1.
- s_valid  out  1  request to the register bank.
- s_wstrb  out  4  latched strobes.
- s_wdata  out  32  latched write data.
- s_addr  out  AW  latched address.
- s_ready  in  1  register-bank acknowledge, asserted one cycle after s_valid.
- s_rdata  in  32  register-bank read data, valid with s_ready.
- gnt  out  2  one-hot owner of the current transaction; 0 in IDLE.

## Operation
- The FSM has three states: IDLE, BUSY and DRAIN.
- IDLE:
  - Sample the request vector {m1_valid, m0_valid} after masking.
  - On any request, grant the winner, latch its addr/wstrb/wdata into the s_* registers, clear the timeout counter, and go to BUSY.
- Round-robin rules:
  - The last-served pointer `last` selects the non-last master when both masters request.
  - `last` updates at grant.
  - Reset sets last=1, so master 0 wins the first contention.
- BUSY:
  - s_valid=1, driven from state.
  - On s_ready: capture s_rdata into the owner's m_rdata, set m_err=0, and go to DRAIN.
  - If the counter reaches TIMEOUT-1 without s_ready: set m_rdata=0, m_err=1, and go to DRAIN.
  - Otherwise the counter increments (8-bit, no wrap within the legal range).
- DRAIN:
  - s_valid=0 and s_ready is ignored. This absorbs the bank's second ready, which it raises because valid was still high on the acknowledge cycle.
  - Owner m_ready=1 for exactly this cycle. m_err is as captured.
  - Next state is IDLE.
- Post-completion mask: in the first IDLE cycle after DRAIN, the just-served master's valid is ignored, so a master that drops valid one cycle late does not issue a duplicate. The other master is not masked.
- Duplicate write: the bank sees s_valid in two consecutive cycles with identical latched data. The duplicate write is idempotent and acceptable.
- Master inputs are ignored outside IDLE. Changing addr/data while waiting has no effect on the issued transaction.
- The non-owner's m_ready, m_err and m_rdata hold their previous values. m_ready is always 0 for the non-owner.

## Timing
- Reset values:
  - State IDLE, gnt=0, last=1, counter=0.
  - s_valid=0; s_wstrb, s_wdata and s_addr all 0.
  - m0_ready, m1_ready, m0_err and m1_err 0; m0_rdata and m1_rdata 0.
- Reset mid-transaction aborts immediately. No m_ready is issued for the aborted request.
- Latency with the register bank (ready one cycle after valid):
  - Cycle t: request sampled in IDLE.
  - t+1: BUSY, s_valid=1.
  - t+2: s_ready; still BUSY, s_valid=1.
  - t+3: DRAIN, m_ready=1.
  - t+4: IDLE, where the served master is masked.
- Minimum issue spacing is 4 cycles when masters alternate, 5 cycles for back-to-back requests from the same master.
- Timeout: BUSY lasts TIMEOUT cycles, and m_ready/m_err assert TIMEOUT+1 cycles after sampling.
- Simultaneous requests in IDLE: exactly one grant, per `last`.
- An s_ready arriving in IDLE or DRAIN is ignored, and no output changes.
- All outputs are registered except s_valid, which is decoded from state.

## Test plan
- Single read: after reset, m0 reads addr 3 while the bank returns 0x12345678. Required: m0_ready pulses at t+3 with m0_rdata=0x12345678 and m0_err=0; gnt=01 during BUSY/DRAIN.
- Byte write: m1 writes wstrb=0100, wdata=0x00AB0000 to addr 5. Required: s_addr=5, s_wstrb=0100 and s_wdata=0x00AB0000 are held during both s_valid cycles; m1_ready pulses once.
- Contention: m0 and m1 hold valid continuously from reset. Required: grants alternate m0, m1, m0, m1, with each m_ready a single-cycle pulse and no duplicate transactions.
- Late drop: m0 keeps valid for one cycle after m0_ready while m1 is idle. Required: no second s_valid transaction is issued for that cycle.
- Timeout: the bank never asserts s_ready and m1 reads. Required: m1_ready=1, m1_err=1 and m1_rdata=0 exactly 17 cycles after sampling (TIMEOUT=16), then IDLE.
- Reset in BUSY: assert rst during s_valid. Required: the next cycle has s_valid=0, gnt=0 and all m_ready=0, and master 0 wins the next contention.
